// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared state encoding, default sizes and stats helper for fifo_reader (stats under FIFO_READER_STATS_EN)
package fifo_reader_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, LAST = 2'd2, COOL = 2'd3} state_t;
   localparam int DEF_DATA_WIDTH = 10;
   localparam int DEF_RD_LATENCY = 2;
   localparam int DEF_BUF_DEPTH = 4;
   localparam int STATS_W = 16;
   function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
      return &v ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/fifo_reader_queue.sv
// reader_queue: circular buffer holding realigned FIFO words until the consumer takes them
module reader_queue import fifo_reader_pkg::*; #(
   parameter int W = DEF_DATA_WIDTH,
   parameter int DEPTH = DEF_BUF_DEPTH,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   output logic [W-1:0]  rd_data,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   // storage has no reset; the head is masked to zero whenever the queue is empty
   always_ff @(posedge clk)
      if (wr_en) mem[wr_ptr] <= wr_data;
   // pointers wrap for free because DEPTH is a power of two
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(wr_en);
         rd_ptr <= rd_ptr + AW'(rd_en);
         count  <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
      end
   assign empty   = count == '0;
   assign full    = count == (AW+1)'(DEPTH);
   assign rd_data = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: pops the FIFO under credit control, realigns read data and serves it over valid/ready (stats under FIFO_READER_STATS_EN)
module fifo_reader import fifo_reader_pkg::*; #(
   parameter int data_width = DEF_DATA_WIDTH,
   parameter int RD_LATENCY = DEF_RD_LATENCY,
   parameter int BUF_DEPTH = DEF_BUF_DEPTH,
   localparam int AW = $clog2(BUF_DEPTH),
   localparam int CW = $clog2(RD_LATENCY + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  empty_fifo,
   input  logic                  almost_empty_fifo,
   input  logic [data_width-1:0] FIFO_data_out,
   output logic                  pop,
   output logic [data_width-1:0] data_out,
   output logic                  valid_out,
   input  logic                  ready_in,
   output logic                  busy
`ifdef FIFO_READER_STATS_EN
   ,
   output logic [STATS_W-1:0]    word_cnt,
   output logic [STATS_W-1:0]    stall_cnt
`endif
);
   state_t                state;
   logic [1:0]            rst_meta;
   logic                  rst_s;
   logic [RD_LATENCY-1:0] sr;
   logic [CW-1:0]         cool_cnt;
   logic [AW:0]           q_count;
   logic                  q_full;
   logic                  q_empty;
   logic [AW+1:0]         committed;
   logic                  credit;
   // assert asynchronously, release two clocks after reset rises
   always_ff @(posedge clk or negedge reset)
      if (!reset) rst_meta <= '0;
      else rst_meta <= {rst_meta[0], 1'b1};
   assign rst_s = rst_meta[1];
   // the pop already on the wire is not yet in sr, so it is charged against the queue as well
   assign committed = (AW+2)'(q_count) + (AW+2)'($countones(sr)) + (AW+2)'(pop);
   assign credit    = committed < (AW+2)'(BUF_DEPTH);
   // track each pop until its word arrives RD_LATENCY cycles later
   always_ff @(posedge clk or negedge rst_s)
      if (!rst_s) sr <= '0;
      else sr <= RD_LATENCY'({sr, pop});
   // pop sequencing: stream while words remain, single pop for the last one, then wait out flag lag
   always_ff @(posedge clk or negedge rst_s)
      if (!rst_s) begin
         state    <= IDLE;
         pop      <= 1'b0;
         cool_cnt <= '0;
      end else begin
         pop <= 1'b0;
         case (state)
            IDLE:
               if (credit && almost_empty_fifo) state <= LAST;
               else if (credit && !empty_fifo) state <= STREAM;
            STREAM:
               if (empty_fifo) state <= IDLE;
               else if (almost_empty_fifo) state <= LAST;
               else pop <= credit;
            LAST:
               if (credit) begin
                  pop      <= 1'b1;
                  cool_cnt <= '0;
                  state    <= COOL;
               end
            COOL:
               if (cool_cnt == CW'(RD_LATENCY)) state <= IDLE;
               else cool_cnt <= cool_cnt + 1'b1;
         endcase
      end
   reader_queue #(.W(data_width), .DEPTH(BUF_DEPTH)) u_queue (
      .clk     (clk),
      .reset   (rst_s),
      .wr_en   (sr[RD_LATENCY-1] && !q_full),
      .wr_data (FIFO_data_out),
      .rd_en   (valid_out && ready_in),
      .rd_data (data_out),
      .count   (q_count),
      .full    (q_full),
      .empty   (q_empty)
   );
   assign valid_out = !q_empty;
   assign busy      = |sr || !q_empty;
`ifdef FIFO_READER_STATS_EN
   // saturating counts of delivered words and stalled cycles
   always_ff @(posedge clk or negedge rst_s)
      if (!rst_s) begin
         word_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (valid_out && ready_in) word_cnt <= sat_inc(word_cnt);
         if (valid_out && !ready_in) stall_cnt <= sat_inc(stall_cnt);
      end
`endif
endmodule

// File: doc/fifo_reader.md
Name: fifo_reader

Overview:
- Read-side controller for the team's push/pop FIFO.
- Watches the FIFO status flags and issues single-cycle pop pulses.
- Realigns each returned word using the known read latency, then buffers words in a small local queue.
- Presents them downstream through a valid/ready handshake, so a stalling consumer never loses data and never over-pops the FIFO.

Parameters:
- data_width, 10, width of FIFO words.
- RD_LATENCY, 2, cycles from pop sampled high to word valid on FIFO_data_out.
- BUF_DEPTH, 4, local queue entries; must be power of 2 and at least RD_LATENCY+1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- empty_fifo  input  1  FIFO empty flag.
- almost_empty_fifo  input  1  FIFO holds one word.
- FIFO_data_out  input  data_width  FIFO read data.
- pop  output  1  pop request to FIFO, one word per high cycle.
- data_out  output  data_width  head of local queue.
- valid_out  output  1  data_out holds a word.
- ready_in  input  1  downstream accepts data_out this cycle.
- busy  output  1  pops in flight or queue non-empty.

Behaviour:
- Reset (reset=0, asynchronous) clears the following; deassertion is synchronized to clk:
  - pop=0, valid_out=0, busy=0, data_out=0.
  - Queue pointers and count = 0, in-flight shift register = 0, state=IDLE.
- Credit rule:
  - pop may assert only when queue_count + inflight_count + 1 <= BUF_DEPTH.
  - inflight_count = number of 1s in the RD_LATENCY-bit pop shift register.
  - Queue overflow is therefore impossible.
- Capture:
  - pop is shifted into the in-flight register each cycle.
  - When the bit exits, FIFO_data_out is written at the queue write pointer the same edge.
- State machine:
  - IDLE: pop=0. Go to STREAM when empty_fifo=0, almost_empty_fifo=0 and credit is available. Go to LAST when almost_empty_fifo=1 and credit is available.
  - STREAM: pop=1 each cycle while credit holds and empty_fifo=0; pop=0 without credit.
    - almost_empty_fifo=1 -> LAST.
    - empty_fifo=1 -> IDLE.
  - LAST: issue exactly one pop (if credit is available; otherwise wait in LAST with pop=0), then go to COOL.
  - COOL: pop=0 for RD_LATENCY+1 cycles, covering the FIFO flag lag, then -> IDLE.
- Handshake:
  - valid_out = (queue_count != 0).
  - Transfer occurs when valid_out && ready_in; the read pointer advances at that edge.
  - data_out is combinational from the head entry and stays stable while valid_out=1 and ready_in=0.
- Simultaneous capture and transfer on the same edge: count unchanged, both pointers advance. Writing into a full queue cannot happen (credit rule).
- Pointers are log2(BUF_DEPTH) bits and wrap modulo BUF_DEPTH; count is log2(BUF_DEPTH)+1 bits.
- busy = (inflight_count != 0) || (queue_count != 0).
- Reset mid-operation: in-flight words are discarded and the FIFO is reset by the same system reset. No pop is asserted in the cycle after reset release.

Optional Feature:
- Macro: FIFO_READER_STATS_EN.
- Defined:
  - Adds output word_cnt (16 bits): increments on each valid_out && ready_in transfer, saturates at 16'hFFFF, cleared by reset.
  - Adds output stall_cnt (16 bits): increments each cycle valid_out && !ready_in, saturates, cleared by reset.
- Undefined: neither port exists; core behaviour is identical.

Decomposition:
- Shared package fifo_reader_pkg:
  - State encodings IDLE=2'd0, STREAM=2'd1, LAST=2'd2, COOL=2'd3.
  - Default data_width/RD_LATENCY/BUF_DEPTH constants.
  - STATS_W=16.
- Sub-module reader_queue: circular buffer with write/read pointers, count, full/empty. Instantiated once.
- FSM, credit logic and latency shift register stay in the top.

Test Plan:
- Reset held low 5 cycles then released, FIFO empty -> pop=0, valid_out=0, busy=0 throughout; pop stays 0 in first post-release cycle.
- FIFO preloaded with 6 words 0x001..0x006, ready_in=1 -> all six delivered in order; first valid_out exactly RD_LATENCY+1 cycles after first pop; FSM ends in IDLE, busy=0.
- Same 6 words, ready_in=0 -> exactly 4 pops issued (BUF_DEPTH) and valid_out held with data_out=0x001 stable. Then ready_in=1 -> remaining 2 popped, all 6 delivered in order with no duplicates.
- Single word 0x2AA in FIFO (almost_empty_fifo=1) -> exactly one pop, LAST then COOL for 3 cycles, then IDLE; word 0x2AA delivered once.
- ready_in toggled 1/0 every cycle with 8 words streaming -> capture and transfer coincide on some edges; count never exceeds 4; output sequence matches input.
- Reset asserted while 2 pops are in flight -> all outputs 0 asynchronously; after release no stale word appears on valid_out. With FIFO_READER_STATS_EN, word_cnt=0 and stall_cnt=0 after reset, and word_cnt=6 after the second scenario.
